sram_mem_stage: RTL and testbench

//  ARM pipeline MEM stage: executes LDR/STR against the external 16-bit SRAM and feeds MEM_Stage_Reg.
//  One 32-bit word takes two 16-bit SRAM accesses. While a transfer runs, the block raises freeze to stall IF/ID/EXE.
//  Non-memory instructions pass straight through in zero cycles.

---
 rtl/sram_mem_stage_pkg.sv | 37 +++
 rtl/sram_wait_counter.sv | 27 ++
 rtl/sram_mem_stage.sv | 140 ++++++++++++++
 tb/tb_sram_mem_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_mem_stage_pkg.sv
// Shared types and helpers for the SRAM-backed MEM stage.
package sram_mem_stage_pkg;

    localparam int SRAM_DATA_LEN = 16;
    localparam int SRAM_ADDR_LEN = 18;

    // Transfer sequencing: one 32-bit word is two 16-bit SRAM accesses.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACC_LO = 2'd1,
        ACC_HI = 2'd2,
        DONE   = 2'd3
    } mem_state_e;

    // Decoded memory request from the EXE register.
    typedef struct packed {
        logic req;
        logic rd;
        logic wr;
    } mem_req_t;

    // A load wins if the decoder ever raises both enables.
    function automatic mem_req_t decode_req(input logic r_en, input logic w_en);
        mem_req_t q;
        q.req = r_en | w_en;
        q.rd  = r_en;
        q.wr  = w_en & ~r_en;
        return q;
    endfunction

    // Byte address to 32-bit word index relative to the SRAM window base.
    function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                               input logic [31:0] base);
        return (byte_addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Load/decrement wait counter; tc marks the last clock of an SRAM phase.
module sram_wait_counter #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          tc
);

    logic [CW-1:0] cnt;

    // Reload on phase entry, then count down to zero and hold there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - CW'(1);
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/sram_mem_stage.sv
// ARM MEM stage: LDR/STR over a 16-bit SRAM, two half-word accesses per word,
// stalling the front of the pipeline while a transfer is in flight.
module sram_mem_stage
    import sram_mem_stage_pkg::*;
#(
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = SRAM_ADDR_LEN
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_en_in,
    input  logic                     mem_r_en_in,
    input  logic                     mem_w_en_in,
    input  logic [31:0]              alu_res_in,
    input  logic [31:0]              val_rm_in,
    input  logic [3:0]               dest_in,
    output logic                     wb_en_out,
    output logic                     mem_r_en_out,
    output logic [31:0]              alu_res_out,
    output logic [31:0]              mem_res_out,
    output logic [3:0]               dest_out,
    output logic                     freeze,
    output logic [SRAM_AW-1:0]       sram_addr,
    output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
    input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
    output logic                     sram_dq_oe,
    output logic                     sram_we_n,
    output logic                     sram_oe_n
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    mem_state_e               state, state_nxt;
    mem_req_t                 req;
    logic                     tc, cnt_load, in_acc, cap_lo, cap_hi;
    logic [31:0]              word_full;
    logic [SRAM_AW-2:0]       word;
    logic [SRAM_DATA_LEN-1:0] lo_q;
    logic                     unused_word_bits;

    assign req       = decode_req(mem_r_en_in, mem_w_en_in);
    assign word_full = word_index(alu_res_in, 32'(BASE_ADDR));
    assign word      = word_full[SRAM_AW-2:0];
    // Addresses beyond the SRAM window simply wrap.
    assign unused_word_bits = ^word_full[31:SRAM_AW-1];

    assign in_acc = (state == ACC_LO) || (state == ACC_HI);
    assign cap_lo = (state == ACC_LO) && tc && req.rd;
    assign cap_hi = (state == ACC_HI) && tc && req.rd;

    // Pass-through fields; the EXE register holds them while frozen.
    assign mem_r_en_out = mem_r_en_in;
    assign alu_res_out  = alu_res_in;
    assign dest_out     = dest_in;

    // Stall from the arrival cycle until DONE; reset drops the stall at once
    // even though the request inputs are still up.
    assign freeze    = rst & req.req & (state != DONE);
    assign wb_en_out = wb_en_in & ~freeze;

    // One counter instance serves both half-word phases.
    sram_wait_counter #(.CW(CW)) u_wait (
        .clk      (clk),
        .rst_n    (rst),
        .load     (cnt_load),
        .load_val (CW'(WAIT_CYCLES - 1)),
        .dec      (in_acc),
        .tc       (tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next state; the wait counter is reloaded on entry to each access phase.
    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        case (state)
            IDLE: begin
                if (req.req) begin
                    state_nxt = ACC_LO;
                    cnt_load  = 1'b1;
                end
            end
            ACC_LO: begin
                if (tc) begin
                    state_nxt = ACC_HI;
                    cnt_load  = 1'b1;
                end
            end
            ACC_HI: begin
                if (tc)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // SRAM pins decode from state so an async reset releases the strobes
    // in the same cycle; outside access phases everything is parked.
    always_comb begin
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        if (in_acc) begin
            sram_addr = {word, (state == ACC_HI)};
            if (req.rd) begin
                sram_oe_n = 1'b0;
            end else if (req.wr) begin
                sram_we_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_dq_out = (state == ACC_HI) ? val_rm_in[31:16] : val_rm_in[15:0];
            end
        end
    end

    // Low half is parked until the high half arrives so mem_res_out
    // updates once per load, on the high capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lo_q        <= '0;
            mem_res_out <= '0;
        end else begin
            if (cap_lo)
                lo_q <= sram_dq_in;
            if (cap_hi)
                mem_res_out <= {sram_dq_in, lo_q};
        end
    end

endmodule

// File: tb/tb_sram_mem_stage.sv
// Bench for sram_mem_stage: W=1 instance for functional/back-to-back/reset
// checks, W=3 instance for stretched timing.
module tb_sram_mem_stage;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    logic        wb_en_in, r_en, w_en, r3, w3;
    logic [31:0] alu_res_in, val_rm_in;
    logic [3:0]  dest_in;

    logic        wb_en_out, mem_r_en_out, freeze, dq_oe, we_n, oe_n;
    logic [31:0] alu_res_out, mem_res_out;
    logic [3:0]  dest_out;
    logic [17:0] addr;
    logic [15:0] dq_out, dq_in;

    logic        wb_en_out3, mem_r_en_out3, freeze3, dq_oe3, we_n3, oe_n3;
    logic [31:0] alu_res_out3, mem_res_out3;
    logic [3:0]  dest_out3;
    logic [17:0] addr3;
    logic [15:0] dq_out3, dq_in3;

    sram_mem_stage #(.BASE_ADDR(1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(r_en), .mem_w_en_in(w_en),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .alu_res_out(alu_res_out),
        .mem_res_out(mem_res_out), .dest_out(dest_out), .freeze(freeze),
        .sram_addr(addr), .sram_dq_out(dq_out), .sram_dq_in(dq_in),
        .sram_dq_oe(dq_oe), .sram_we_n(we_n), .sram_oe_n(oe_n)
    );

    sram_mem_stage #(.BASE_ADDR(1024), .WAIT_CYCLES(3), .SRAM_AW(18)) dut3 (
        .clk(clk), .rst(rst), .wb_en_in(wb_en_in), .mem_r_en_in(r3), .mem_w_en_in(w3),
        .alu_res_in(alu_res_in), .val_rm_in(val_rm_in), .dest_in(dest_in),
        .wb_en_out(wb_en_out3), .mem_r_en_out(mem_r_en_out3), .alu_res_out(alu_res_out3),
        .mem_res_out(mem_res_out3), .dest_out(dest_out3), .freeze(freeze3),
        .sram_addr(addr3), .sram_dq_out(dq_out3), .sram_dq_in(dq_in3),
        .sram_dq_oe(dq_oe3), .sram_we_n(we_n3), .sram_oe_n(oe_n3)
    );

    // Power-on SRAM contents.
    function automatic logic [15:0] init_val(input int i);
        case (i)
            2:       return 16'h1234;
            3:       return 16'hABCD;
            default: return 16'(16'h1000 + i);
        endcase
    endfunction

    // SRAM model for the W=1 instance: written by the DUT's strobe.
    logic [15:0] sram [0:255];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) sram[i] <= init_val(i);
        end else if (!we_n) begin
            sram[addr[7:0]] <= dq_out;
        end
    end
    assign dq_in  = oe_n  ? 16'h0 : sram[addr[7:0]];
    // W=3 instance reads a fixed address-derived pattern.
    assign dq_in3 = oe_n3 ? 16'h0 : (addr3[15:0] ^ 16'h5A5A);

    logic [15:0] exp_mem [0:255];
    logic [31:0] sb [$];
    logic [31:0] last_load;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic idle();
        step();
        r_en = 1'b0; w_en = 1'b0;
        samp();
        chk("idle_freeze", freeze, 0);
        chk("idle_we_n", we_n, 1);
    endtask

    // Issue one memory op on the W=1 instance and walk IDLE/LO/HI/DONE.
    task automatic mem_op(input bit rd, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] w;
        logic [7:0]  lo_a;
        w    = (a - 32'd1024) >> 2;
        lo_a = 8'(w * 2);
        step();
        r_en = rd; w_en = !rd; wb_en_in = 1'b1;
        alu_res_in = a; val_rm_in = d; dest_in = a[5:2];
        if (rd) begin
            sb.push_back({exp_mem[lo_a + 8'd1], exp_mem[lo_a]});
        end else begin
            exp_mem[lo_a]        = d[15:0];
            exp_mem[lo_a + 8'd1] = d[31:16];
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            samp();
            chk("freeze", freeze, 32'(k < 3));
            chk("wb_en_out", wb_en_out, 32'(k == 3));
            chk("dest_out", dest_out, a[5:2]);
            chk("mem_r_en_out", mem_r_en_out, rd);
            if (k == 1 || k == 2) begin
                chk("addr", addr, 32'(lo_a) + 32'(k == 2));
                chk("oe_n", oe_n, !rd);
                chk("we_n", we_n, rd);
                chk("dq_oe", dq_oe, !rd);
                if (!rd) chk("dq_out", dq_out, (k == 1) ? d[15:0] : d[31:16]);
            end else begin
                chk("we_n_park", we_n, 1);
                chk("oe_n_park", oe_n, 1);
                chk("dq_oe_park", dq_oe, 0);
            end
        end
        if (rd) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 1, 0);
            end else begin
                last_load = sb.pop_front();
                chk("mem_res", mem_res_out, last_load);
            end
        end else begin
            chk("mem_res_hold", mem_res_out, last_load);
        end
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] e3;
        for (int i = 0; i < 256; i++) exp_mem[i] = init_val(i);
        last_load = 32'h0;
        rst = 1'b0; wb_en_in = 1'b0; r_en = 1'b0; w_en = 1'b0; r3 = 1'b0; w3 = 1'b0;
        alu_res_in = 32'd1028; val_rm_in = 32'h0; dest_in = 4'h0;
        #12;
        chk("rst_freeze", freeze, 0);
        chk("rst_we_n", we_n, 1);
        chk("rst_oe_n", oe_n, 1);
        chk("rst_dq_oe", dq_oe, 0);
        chk("rst_mem_res", mem_res_out, 0);
        chk("rst_addr", addr, 0);
        chk("rst_dq_out", dq_out, 0);
        step();
        rst = 1'b1;

        // Pass-through.
        for (int i = 0; i < 3; i++) begin
            step();
            v = $urandom;
            r_en = 1'b0; w_en = 1'b0; wb_en_in = 1'b1; alu_res_in = v; dest_in = 4'(i + 5);
            samp();
            chk("pt_freeze", freeze, 0);
            chk("pt_wb_en", wb_en_out, 1);
            chk("pt_alu", alu_res_out, v);
            chk("pt_dest", dest_out, 32'(i + 5));
            chk("pt_we_n", we_n, 1);
            chk("pt_oe_n", oe_n, 1);
        end

        mem_op(1'b1, 32'd1028, 32'h0);           // expects ABCD1234
        idle();
        mem_op(1'b0, 32'd1028, 32'hDEADBEEF);
        idle();
        mem_op(1'b1, 32'd1028, 32'h0);           // reads back DEADBEEF
        idle();
        // Back-to-back: load, store, load with no idle gap.
        mem_op(1'b1, 32'd1032, 32'h0);
        mem_op(1'b0, 32'd1036, 32'hCAFEF00D);
        mem_op(1'b1, 32'd1036, 32'h0);
        idle();
        mem_op(1'b1, 32'd1024, 32'h0);           // window base -> halves 0/1
        idle();

        // W=3 load at word 5 (halves 10/11).
        e3 = {16'd11 ^ 16'h5A5A, 16'd10 ^ 16'h5A5A};
        step();
        r3 = 1'b1; alu_res_in = 32'd1044; dest_in = 4'h9;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            samp();
            chk("w3_freeze", freeze3, 32'(k < 7));
            chk("w3_wb_en", wb_en_out3, 32'(k == 7));
            chk("w3_we_n", we_n3, 1);
            chk("w3_dq_oe", dq_oe3, 0);
            if (k >= 1 && k <= 3) begin
                chk("w3_addr_lo", addr3, 10);
                chk("w3_oe_n", oe_n3, 0);
            end
            if (k >= 4 && k <= 6) begin
                chk("w3_addr_hi", addr3, 11);
                chk("w3_oe_n", oe_n3, 0);
            end
        end
        chk("w3_mem_res", mem_res_out3, e3);
        chk("w3_alu", alu_res_out3, 32'd1044);
        chk("w3_dest", dest_out3, 9);
        chk("w3_r_en", mem_r_en_out3, 1);
        chk("w3_dq_out", dq_out3, 0);
        step();
        r3 = 1'b0;

        // Reset asserted in the middle of a store's ACC_HI phase.
        step();
        w_en = 1'b1; r_en = 1'b0; alu_res_in = 32'd1040; val_rm_in = 32'h55AA33CC;
        step();
        step();
        chk("rm_we_n_before", we_n, 0);
        chk("rm_addr_before", addr, 9);
        rst = 1'b0;
        #1;
        chk("rm_we_n", we_n, 1);
        chk("rm_dq_oe", dq_oe, 0);
        chk("rm_freeze", freeze, 0);
        chk("rm_mem_res", mem_res_out, 0);
        chk("rm_addr", addr, 0);
        step();
        w_en = 1'b0; rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            samp();
            chk("rm_after_freeze", freeze, 0);
            chk("rm_after_we_n", we_n, 1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety bound on total run time.
    initial begin
        #200000;
        $display("FAIL timeout got %0d exp %0d", 0, 1);
        $fatal(1);
    end

endmodule
